// File: rtl/dwpe_seq_ctrl.sv
// Depthwise PE array sequencer: walks K*K taps per channel,
// drains the PE pipeline and hands each result block downstream.
module dwpe_seq_ctrl #(
    parameter int K      = 3,
    parameter int CW     = 8,
    parameter int AW     = 12,
    parameter int PE_LAT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [CW-1:0]                        cfg_ch,
    output logic                                 busy,
    output logic                                 done,
    input  logic                                 pix_valid,
    output logic [AW-1:0]                        wbuf_addr,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] win_x,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] win_y,
    output logic [CW-1:0]                        ch_idx,
    output logic                                 pe_ena,
    output logic                                 pe_first,
    output logic                                 pe_last,
    output logic                                 res_valid,
    input  logic                                 res_ready
);

    localparam int TAPS = K * K;
    localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int XW   = (K > 1) ? $clog2(K) : 1;
    localparam int DW   = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tap_q, tap_d;
    logic [XW-1:0] wx_q, wx_d;
    logic [XW-1:0] wy_q, wy_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [CW-1:0] cfg_q, cfg_d;
    logic [DW-1:0] drn_q, drn_d;
    logic          fire;
    logic          last_tap;

    assign last_tap = (tap_q == TW'(TAPS - 1));

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        ch_d    = ch_q;
        cfg_d   = cfg_q;
        drn_d   = drn_q;
        fire    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_d   = cfg_ch;
                    ch_d    = '0;
                    tap_d   = '0;
                    wx_d    = '0;
                    wy_d    = '0;
                    state_d = (cfg_ch == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pix_valid) begin
                    fire = 1'b1;
                    if (last_tap) begin
                        tap_d   = '0;
                        wx_d    = '0;
                        wy_d    = '0;
                        drn_d   = DW'(PE_LAT - 1);
                        state_d = S_DRAIN;
                    end else begin
                        tap_d = tap_q + 1'b1;
                        if (wx_q == XW'(K - 1)) begin
                            wx_d = '0;
                            wy_d = wy_q + 1'b1;
                        end else begin
                            wx_d = wx_q + 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drn_q == '0) begin
                    state_d = S_OUT;
                end else begin
                    drn_d = drn_q - 1'b1;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    if (ch_q == cfg_q - 1'b1) begin
                        state_d = S_DONE;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE: begin
                ch_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PE strobes are registered to line up with the 1-cycle weight read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            wx_q     <= '0;
            wy_q     <= '0;
            ch_q     <= '0;
            cfg_q    <= '0;
            drn_q    <= '0;
            pe_ena   <= 1'b0;
            pe_first <= 1'b0;
            pe_last  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
            ch_q     <= ch_d;
            cfg_q    <= cfg_d;
            drn_q    <= drn_d;
            pe_ena   <= fire;
            pe_first <= fire & (tap_q == '0);
            pe_last  <= fire & last_tap;
        end
    end

    assign wbuf_addr = AW'(ch_q) * AW'(TAPS) + AW'(tap_q);
    assign win_x     = wx_q;
    assign win_y     = wy_q;
    assign ch_idx    = ch_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign res_valid = (state_q == S_OUT);

endmodule

// File: tb/tb_dwpe_seq_ctrl.sv
// Directed bench for dwpe_seq_ctrl (K=3, PE_LAT=2).
// Cycle c = values observed just after the c-th edge following start.
module tb_dwpe_seq_ctrl;

    localparam int K      = 3;
    localparam int CW     = 8;
    localparam int AW     = 12;
    localparam int PE_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] cfg_ch;
    logic          busy;
    logic          done;
    logic          pix_valid;
    logic [AW-1:0] wbuf_addr;
    logic [1:0]    win_x;
    logic [1:0]    win_y;
    logic [CW-1:0] ch_idx;
    logic          pe_ena;
    logic          pe_first;
    logic          pe_last;
    logic          res_valid;
    logic          res_ready;

    int checks = 0;
    int errors = 0;

    dwpe_seq_ctrl #(.K(K), .CW(CW), .AW(AW), .PE_LAT(PE_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_ch    (cfg_ch),
        .busy      (busy),
        .done      (done),
        .pix_valid (pix_valid),
        .wbuf_addr (wbuf_addr),
        .win_x     (win_x),
        .win_y     (win_y),
        .ch_idx    (ch_idx),
        .pe_ena    (pe_ena),
        .pe_first  (pe_first),
        .pe_last   (pe_last),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single-channel tile, continuous valid/ready
    task automatic run_one(input string t);
        cfg_ch    = 8'd1;
        start     = 1'b1;
        pix_valid = 1'b1;
        res_ready = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step;
            start = 1'b0;
            chk($sformatf("%s addr c%0d", t, c), 32'(wbuf_addr),
                (c <= 9) ? 32'(c - 1) : 32'd0);
            if (c <= 9) begin
                chk($sformatf("%s wx c%0d", t, c), 32'(win_x), 32'((c - 1) % 3));
                chk($sformatf("%s wy c%0d", t, c), 32'(win_y), 32'((c - 1) / 3));
                chk($sformatf("%s ch c%0d", t, c), 32'(ch_idx), 32'd0);
            end
            chk($sformatf("%s ena c%0d", t, c), 32'(pe_ena), 32'(c >= 2 && c <= 10));
            chk($sformatf("%s first c%0d", t, c), 32'(pe_first), 32'(c == 2));
            chk($sformatf("%s last c%0d", t, c), 32'(pe_last), 32'(c == 10));
            chk($sformatf("%s rv c%0d", t, c), 32'(res_valid), 32'(c == 12));
            chk($sformatf("%s done c%0d", t, c), 32'(done), 32'(c == 13));
            chk($sformatf("%s busy c%0d", t, c), 32'(busy), 32'(c <= 13));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_ch    = '0;
        pix_valid = 1'b0;
        res_ready = 1'b0;
        step;
        step;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst ena", 32'(pe_ena), 32'd0);
        chk("rst first", 32'(pe_first), 32'd0);
        chk("rst last", 32'(pe_last), 32'd0);
        chk("rst rv", 32'(res_valid), 32'd0);
        chk("rst addr", 32'(wbuf_addr), 32'd0);
        chk("rst wx", 32'(win_x), 32'd0);
        chk("rst wy", 32'(win_y), 32'd0);
        chk("rst ch", 32'(ch_idx), 32'd0);
        rst_n = 1'b1;
        step;

        run_one("t1");

        // Three channels; a second start and a cfg_ch change mid-tile
        cfg_ch    = 8'd3;
        start     = 1'b1;
        pix_valid = 1'b1;
        res_ready = 1'b1;
        for (int c = 1; c <= 38; c++) begin
            int n;
            int r;
            step;
            start  = (c == 5);
            cfg_ch = 8'd7;
            n = (c - 1) / 12;
            r = (c - 1) % 12;
            if (r < 9 && c <= 36) begin
                chk($sformatf("t2 addr c%0d", c), 32'(wbuf_addr), 32'(9 * n + r));
                chk($sformatf("t2 ch c%0d", c), 32'(ch_idx), 32'(n));
            end
            chk($sformatf("t2 ena c%0d", c), 32'(pe_ena),
                32'(r >= 1 && r <= 9 && c <= 36));
            chk($sformatf("t2 rv c%0d", c), 32'(res_valid), 32'(r == 11 && c <= 36));
            chk($sformatf("t2 done c%0d", c), 32'(done), 32'(c == 37));
            chk($sformatf("t2 busy c%0d", c), 32'(busy), 32'(c <= 37));
        end
        start = 1'b0;

        // pix_valid low for 3 cycles while tap 4 is pending
        cfg_ch    = 8'd1;
        start     = 1'b1;
        pix_valid = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            step;
            start     = 1'b0;
            pix_valid = !(c >= 5 && c <= 7);
            if (c <= 12) begin
                chk($sformatf("t3 addr c%0d", c), 32'(wbuf_addr),
                    (c <= 4) ? 32'(c - 1) : (c <= 7) ? 32'd4 : 32'(c - 4));
            end
            chk($sformatf("t3 ena c%0d", c), 32'(pe_ena),
                32'((c >= 2 && c <= 5) || (c >= 9 && c <= 13)));
            chk($sformatf("t3 last c%0d", c), 32'(pe_last), 32'(c == 13));
            chk($sformatf("t3 rv c%0d", c), 32'(res_valid), 32'(c == 15));
            chk($sformatf("t3 done c%0d", c), 32'(done), 32'(c == 16));
            chk($sformatf("t3 busy c%0d", c), 32'(busy), 32'(c <= 16));
        end
        pix_valid = 1'b1;

        // res_ready low for 5 cycles on channel 0 of 2
        cfg_ch    = 8'd2;
        start     = 1'b1;
        res_ready = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            step;
            start     = 1'b0;
            res_ready = !(c >= 12 && c <= 16);
            if (c >= 12 && c <= 17) begin
                chk($sformatf("t4 hold ch c%0d", c), 32'(ch_idx), 32'd0);
            end
            if (c >= 18 && c <= 26) begin
                chk($sformatf("t4 addr c%0d", c), 32'(wbuf_addr), 32'(c - 9));
                chk($sformatf("t4 ch c%0d", c), 32'(ch_idx), 32'd1);
            end
            chk($sformatf("t4 ena c%0d", c), 32'(pe_ena),
                32'((c >= 2 && c <= 10) || (c >= 19 && c <= 27)));
            chk($sformatf("t4 rv c%0d", c), 32'(res_valid),
                32'((c >= 12 && c <= 17) || c == 29));
            chk($sformatf("t4 done c%0d", c), 32'(done), 32'(c == 30));
            chk($sformatf("t4 busy c%0d", c), 32'(busy), 32'(c <= 30));
        end
        res_ready = 1'b1;

        // Empty tile; start held through the DONE cycle is ignored
        cfg_ch = 8'd0;
        start  = 1'b1;
        step;
        cfg_ch = 8'd2;
        chk("t5 done c1", 32'(done), 32'd1);
        chk("t5 busy c1", 32'(busy), 32'd1);
        chk("t5 ena c1", 32'(pe_ena), 32'd0);
        step;
        start = 1'b0;
        chk("t5 done c2", 32'(done), 32'd0);
        chk("t5 busy c2", 32'(busy), 32'd0);
        chk("t5 ena c2", 32'(pe_ena), 32'd0);
        chk("t5 rv c2", 32'(res_valid), 32'd0);

        // Reset during DRAIN of channel 1 of 3
        cfg_ch = 8'd3;
        start  = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step;
            start = 1'b0;
        end
        chk("t6 pre ch", 32'(ch_idx), 32'd1);
        chk("t6 pre busy", 32'(busy), 32'd1);
        chk("t6 pre rv", 32'(res_valid), 32'd0);
        rst_n = 1'b0;
        step;
        chk("t6 busy", 32'(busy), 32'd0);
        chk("t6 done", 32'(done), 32'd0);
        chk("t6 ena", 32'(pe_ena), 32'd0);
        chk("t6 first", 32'(pe_first), 32'd0);
        chk("t6 last", 32'(pe_last), 32'd0);
        chk("t6 rv", 32'(res_valid), 32'd0);
        chk("t6 addr", 32'(wbuf_addr), 32'd0);
        chk("t6 wx", 32'(win_x), 32'd0);
        chk("t6 wy", 32'(win_y), 32'd0);
        chk("t6 ch", 32'(ch_idx), 32'd0);
        step;
        rst_n = 1'b1;
        chk("t6 hold done", 32'(done), 32'd0);
        chk("t6 hold rv", 32'(res_valid), 32'd0);
        step;
        chk("t6 post done", 32'(done), 32'd0);
        chk("t6 post busy", 32'(busy), 32'd0);
        chk("t6 post rv", 32'(res_valid), 32'd0);

        run_one("t6r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
